// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: datapath modes,
// burst direction encodings and the burst controller state type.
package usr_pkg;

    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHR  = 2'b01,
        USR_SHL  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic {
        BST_IDLE = 1'b0,
        BST_RUN  = 1'b1
    } usr_bst_state_e;

endpackage

// File: rtl/usr_if.sv
// Control/data bundle of the universal shift register. The master side
// drives mode, serial/parallel inputs and burst requests; the slave side
// (the register itself) returns the parallel and serial outputs and status.
interface usr_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             clr;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             dir;
    logic [WIDTH-1:0] po;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

    modport master (
        output clr, mode, sin_r, sin_l, pin, start, len, dir,
        input  po, sout_r, sout_l, busy, done
    );

    modport slave (
        input  clr, mode, sin_r, sin_l, pin, start, len, dir,
        output po, sout_r, sout_l, busy, done
    );
endinterface

// File: rtl/usr_burst_ctrl.sv
// Burst engine: captures a clamped shift count and direction on start,
// then steers the datapath through that many shifts and pulses done.
//
//   state    | meaning
//   BST_IDLE | no burst; live mode drives the datapath, start is sampled
//   BST_RUN  | burst active; one shift per edge in the captured direction
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             i_clr,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_dir,
    input  usr_mode_e        i_mode,
    output logic             o_busy,
    output logic             o_done,
    output usr_mode_e        o_eff_mode
);

    usr_bst_state_e   r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_dir;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] w_len_clamped;

    // Requests longer than the register saturate to one full register of shifts.
    assign w_len_clamped = (i_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : i_len;

    // Burst FSM with down-counter; done defaults low so it only ever pulses.
    always_ff @(negedge clk or negedge rs) begin
        if (!rs) begin
            r_state <= BST_IDLE;
            r_count <= '0;
            r_dir   <= DIR_RIGHT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_clr) begin
                r_state <= BST_IDLE;
                r_count <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    BST_IDLE: begin
                        if (i_start) begin
                            r_dir <= i_dir;
                            if (w_len_clamped == '0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_count <= w_len_clamped;
                                r_busy  <= 1'b1;
                                r_state <= BST_RUN;
                            end
                        end
                    end
                    BST_RUN: begin
                        r_count <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= BST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= BST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Mode seen by the datapath: burst direction while running, hold on the
    // capturing edge, otherwise the live mode input.
    always_comb begin
        o_eff_mode = i_mode;
        if (r_state == BST_RUN) begin
            o_eff_mode = (r_dir == DIR_LEFT) ? USR_SHL : USR_SHR;
        end else if (i_start) begin
            o_eff_mode = USR_HOLD;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load,
// with a burst engine for N back-to-back shifts. State updates on the
// falling edge of clk; rs is an asynchronous active-low reset.
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input logic  clk,
    input logic  rs,
    usr_if.slave bus
);

    logic [WIDTH-1:0] r_po;
    usr_mode_e        w_eff_mode;
    logic             w_busy;
    logic             w_done;

    usr_burst_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_burst_ctrl (
        .clk        (clk),
        .rs         (rs),
        .i_clr      (bus.clr),
        .i_start    (bus.start),
        .i_len      (bus.len),
        .i_dir      (bus.dir),
        .i_mode     (usr_mode_e'(bus.mode)),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_eff_mode (w_eff_mode)
    );

    // Register contents: clear wins, otherwise apply the effective mode.
    always_ff @(negedge clk or negedge rs) begin
        if (!rs) begin
            r_po <= '0;
        end else if (bus.clr) begin
            r_po <= '0;
        end else begin
            case (w_eff_mode)
                USR_SHR:  r_po <= {bus.sin_r, r_po[WIDTH-1:1]};
                USR_SHL:  r_po <= {r_po[WIDTH-2:0], bus.sin_l};
                USR_LOAD: r_po <= bus.pin;
                default:  r_po <= r_po;
            endcase
        end
    end

    assign bus.po     = r_po;
    assign bus.sout_r = r_po[0];
    assign bus.sout_l = r_po[WIDTH-1];
    assign bus.busy   = w_busy;
    assign bus.done   = w_done;

endmodule
